// File: rtl/lsu_addrcheck_pipe.sv
// LSU address check: classifies the dc1 access (DCCM / PIC / external),
// derives region attributes and a prioritised fault code, then carries the
// result through dc2/dc3 with freeze/flush control and a sticky fault capture.
module lsu_addrcheck_pipe #(
  parameter bit          DCCM_ENABLE = 1'b1,
  parameter logic [31:0] DCCM_SADR   = 32'hF004_0000,
  parameter logic [31:0] DCCM_SIZE   = 32'h0001_0000,
  parameter logic [31:0] PIC_SADR    = 32'hF00C_0000,
  parameter logic [31:0] PIC_SIZE    = 32'h0000_8000,
  parameter bit          ICCM_ENABLE = 1'b1,
  parameter logic [3:0]  ICCM_REGION = 4'hE,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush_dc2,
  input  logic             valid_dc1,
  input  logic             dma_dc1,
  input  logic [1:0]       size_dc1,
  input  logic [31:0]      addr_dc1,
  input  logic [31:0]      mrac,
  input  logic             fault_clr,
  output logic             valid_dc2,
  output logic             valid_dc3,
  output logic             addr_in_dccm_dc2,
  output logic             addr_in_pic_dc2,
  output logic             addr_external_dc2,
  output logic             cacheable_dc2,
  output logic             sideeffects_dc2,
  output logic             sideeffects_dc3,
  output logic             access_fault_dc2,
  output logic             misaligned_fault_dc2,
  output logic [2:0]       fault_code_dc2,
  output logic             fault_lock,
  output logic [31:0]      fault_addr,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] fault_cnt
);

  // Bases are aligned to their power-of-two sizes, so a range hit is a masked compare.
  localparam logic [31:0] DCCM_MASK = ~(DCCM_SIZE - 32'd1);
  localparam logic [31:0] PIC_MASK  = ~(PIC_SIZE - 32'd1);

  typedef struct packed {
    logic        dccm;
    logic        pic;
    logic        ext;
    logic        cache;
    logic        side;
    logic [2:0]  code;
    logic [31:0] addr;
  } chk_t;

  logic [32:0] end_full;
  logic [31:0] end_a;
  logic        wrap;
  logic        st_dr, en_dr, st_pr, en_pr;   // range hits
  logic        st_dg, en_dg, st_pg, en_pg;   // 256MB region hits
  logic [3:0]  rgn;
  logic        iccm_hit, aligned;
  chk_t        s1, s2_q;
  logic [2:1]  vld_pipe_q;
  logic        side3_q;
  logic        fault_hit;
  logic        fault_lock_q;
  logic [31:0] fault_addr_q;
  logic [2:0]  fault_code_q;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  assign end_full = {1'b0, addr_dc1} + (33'd1 << size_dc1) - 33'd1;
  assign end_a    = end_full[31:0];
  assign wrap     = end_full[32];
  assign rgn      = addr_dc1[31:28];

  assign st_dr = DCCM_ENABLE & ((addr_dc1 & DCCM_MASK) == DCCM_SADR);
  assign en_dr = DCCM_ENABLE & ((end_a & DCCM_MASK) == DCCM_SADR);
  assign st_dg = DCCM_ENABLE & (addr_dc1[31:28] == DCCM_SADR[31:28]);
  assign en_dg = DCCM_ENABLE & (end_a[31:28] == DCCM_SADR[31:28]);
  assign st_pr = ((addr_dc1 & PIC_MASK) == PIC_SADR);
  assign en_pr = ((end_a & PIC_MASK) == PIC_SADR);
  assign st_pg = (addr_dc1[31:28] == PIC_SADR[31:28]);
  assign en_pg = (end_a[31:28] == PIC_SADR[31:28]);
  assign iccm_hit = ICCM_ENABLE & (rgn == ICCM_REGION);

  // Natural alignment for the access size
  always_comb begin
    aligned = 1'b1;
    unique case (size_dc1)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr_dc1[0];
      2'd2:    aligned = (addr_dc1[1:0] == 2'b00);
      default: aligned = (addr_dc1[2:0] == 3'b000);
    endcase
  end

  // dc1 classification, attributes and prioritised fault code
  always_comb begin
    s1       = '0;
    s1.addr  = addr_dc1;
    s1.dccm  = st_dr & en_dr;
    s1.pic   = st_pr & en_pr;
    s1.ext   = ~(s1.dccm | s1.pic);
    s1.side  = mrac[{rgn, 1'b1}] & ~(st_dg | st_pg | iccm_hit);
    s1.cache = mrac[{rgn, 1'b0}] & s1.ext;
    if (wrap)
      s1.code = 3'd4;
    else if ((st_dg & ~st_dr & ~st_pr) | (en_dg & ~en_dr & ~en_pr))
      s1.code = 3'd1;
    else if ((st_pg & ~st_dr & ~st_pr) | (en_pg & ~en_dr & ~en_pr))
      s1.code = 3'd2;
    else if (s1.pic & ((size_dc1 != 2'd2) | (addr_dc1[1:0] != 2'b00)))
      s1.code = 3'd3;
    else if (st_dr & ~en_dr)
      s1.code = 3'd7;
    else if (s1.ext & (addr_dc1[31:28] != end_a[31:28]))
      s1.code = 3'd5;
    else if (s1.ext & s1.side & ~aligned)
      s1.code = 3'd6;
    else
      s1.code = 3'd0;
    // DMA and empty slots never report faults
    if (~valid_dc1 | dma_dc1)
      s1.code = 3'd0;
  end

  // Stage data advances only when not frozen
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_q    <= '0;
      side3_q <= 1'b0;
    end else if (!freeze) begin
      s2_q    <= s1;
      side3_q <= s2_q.side;
    end
  end

  // Stage valids: flush kills dc2/dc3 even while frozen
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      vld_pipe_q <= '0;
    else if (flush_dc2)
      vld_pipe_q <= '0;
    else if (!freeze)
      vld_pipe_q <= {vld_pipe_q[1], valid_dc1};
  end

  // A fault qualifies only when dc2 actually retires it this edge
  assign fault_hit = vld_pipe_q[1] & (s2_q.code != 3'd0) & ~freeze & ~flush_dc2;

  // Sticky capture; a clear arriving with a new fault re-arms onto that fault
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_lock_q <= 1'b0;
      fault_addr_q <= '0;
      fault_code_q <= '0;
    end else if (fault_hit & (~fault_lock_q | fault_clr)) begin
      fault_lock_q <= 1'b1;
      fault_addr_q <= s2_q.addr;
      fault_code_q <= s2_q.code;
    end else if (fault_clr) begin
      fault_lock_q <= 1'b0;
    end
  end

  assign fault_cnt_d = (fault_hit & (fault_cnt_q != {CNT_W{1'b1}})) ?
                       fault_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : fault_cnt_q;

  // Saturating count of every retired fault, independent of the lock
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      fault_cnt_q <= '0;
    else
      fault_cnt_q <= fault_cnt_d;
  end

  assign valid_dc2            = vld_pipe_q[1];
  assign valid_dc3            = vld_pipe_q[2];
  assign addr_in_dccm_dc2     = valid_dc2 & s2_q.dccm;
  assign addr_in_pic_dc2      = valid_dc2 & s2_q.pic;
  assign addr_external_dc2    = valid_dc2 & s2_q.ext;
  assign cacheable_dc2        = valid_dc2 & s2_q.cache;
  assign sideeffects_dc2      = valid_dc2 & s2_q.side;
  assign sideeffects_dc3      = valid_dc3 & side3_q;
  assign fault_code_dc2       = valid_dc2 ? s2_q.code : 3'd0;
  assign access_fault_dc2     = valid_dc2 & (s2_q.code inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7});
  assign misaligned_fault_dc2 = valid_dc2 & (s2_q.code inside {3'd5, 3'd6});
  assign fault_lock           = fault_lock_q;
  assign fault_addr           = fault_addr_q;
  assign fault_code           = fault_code_q;
  assign fault_cnt            = fault_cnt_q;

endmodule

// File: tb/tb_lsu_addrcheck_pipe.sv
// Scoreboard bench for lsu_addrcheck_pipe: the driver pushes one expected dc1
// result per edge, the monitor pops it and advances a behavioural pipe/fault model.
module tb_lsu_addrcheck_pipe;
  localparam int          CNT_W  = 8;
  localparam logic [31:0] DBASE  = 32'hF004_0000;
  localparam logic [31:0] DSIZE  = 32'h0001_0000;
  localparam logic [31:0] PBASE  = 32'hF00C_0000;
  localparam logic [31:0] PSIZE  = 32'h0000_8000;
  localparam logic [3:0]  ICCM_R = 4'hE;

  logic clk, rst_l, freeze, flush_dc2, valid_dc1, dma_dc1, fault_clr;
  logic [1:0] size_dc1;
  logic [31:0] addr_dc1, mrac;
  logic valid_dc2, valid_dc3, addr_in_dccm_dc2, addr_in_pic_dc2, addr_external_dc2;
  logic cacheable_dc2, sideeffects_dc2, sideeffects_dc3, access_fault_dc2, misaligned_fault_dc2;
  logic [2:0] fault_code_dc2, fault_code;
  logic fault_lock;
  logic [31:0] fault_addr;
  logic [CNT_W-1:0] fault_cnt;

  lsu_addrcheck_pipe #(
    .DCCM_ENABLE(1'b1), .DCCM_SADR(DBASE), .DCCM_SIZE(DSIZE), .PIC_SADR(PBASE),
    .PIC_SIZE(PSIZE), .ICCM_ENABLE(1'b1), .ICCM_REGION(ICCM_R), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush_dc2(flush_dc2),
    .valid_dc1(valid_dc1), .dma_dc1(dma_dc1), .size_dc1(size_dc1), .addr_dc1(addr_dc1),
    .mrac(mrac), .fault_clr(fault_clr), .valid_dc2(valid_dc2), .valid_dc3(valid_dc3),
    .addr_in_dccm_dc2(addr_in_dccm_dc2), .addr_in_pic_dc2(addr_in_pic_dc2),
    .addr_external_dc2(addr_external_dc2), .cacheable_dc2(cacheable_dc2),
    .sideeffects_dc2(sideeffects_dc2), .sideeffects_dc3(sideeffects_dc3),
    .access_fault_dc2(access_fault_dc2), .misaligned_fault_dc2(misaligned_fault_dc2),
    .fault_code_dc2(fault_code_dc2), .fault_lock(fault_lock), .fault_addr(fault_addr),
    .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit rst, frz, fl, clr, v;
    bit dccm, pic, ext, cache, side;
    bit [2:0] code;
    bit [31:0] addr;
  } ent_t;

  ent_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  bit stim_done = 0;

  function automatic bit in_rng(longint unsigned x, longint unsigned base, longint unsigned sz);
    return (x >= base) && (x < base + sz);
  endfunction

  function automatic bit same_rgn(longint unsigned x, longint unsigned base);
    return (x >> 28) == (base >> 28);
  endfunction

  // Reference: the access rules evaluated with plain 64-bit arithmetic
  function automatic ent_t ref_chk(bit rst, bit frz, bit fl, bit clr, bit v, bit dma,
                                   bit [1:0] sz, bit [31:0] a, bit [31:0] mr);
    ent_t r;
    longint unsigned s, e, blen;
    bit wrap, sd, ed, sp, ep, sdg, edg, spg, epg, aligned;
    int rg;
    r.rst = rst; r.frz = frz; r.fl = fl; r.clr = clr; r.v = v; r.addr = a;
    s = a; blen = 64'd1 << sz; e = s + blen - 1;
    wrap = (e >> 32) != 0;
    e = e & 64'hFFFF_FFFF;
    sd = in_rng(s, DBASE, DSIZE); ed = in_rng(e, DBASE, DSIZE);
    sp = in_rng(s, PBASE, PSIZE); ep = in_rng(e, PBASE, PSIZE);
    sdg = same_rgn(s, DBASE); edg = same_rgn(e, DBASE);
    spg = same_rgn(s, PBASE); epg = same_rgn(e, PBASE);
    rg = int'(s >> 28);
    r.dccm  = sd && ed;
    r.pic   = sp && ep;
    r.ext   = !r.dccm && !r.pic;
    r.side  = mr[2*rg+1] && !(sdg || spg || rg == int'(ICCM_R));
    r.cache = mr[2*rg] && r.ext;
    aligned = (s % blen) == 0;
    if (wrap) r.code = 4;
    else if ((sdg && !sd && !sp) || (edg && !ed && !ep)) r.code = 1;
    else if ((spg && !sd && !sp) || (epg && !ed && !ep)) r.code = 2;
    else if (r.pic && (sz != 2 || (s % 4) != 0)) r.code = 3;
    else if (sd && !ed) r.code = 7;
    else if (r.ext && (s >> 28) != (e >> 28)) r.code = 5;
    else if (r.ext && r.side && !aligned) r.code = 6;
    else r.code = 0;
    if (!v || dma) r.code = 0;
    return r;
  endfunction

  function automatic bit [31:0] pick_addr();
    bit [31:0] a;
    case ($urandom % 6)
      0: a = DBASE + ($urandom % 32'h1_0010);
      1: a = PBASE - 8 + ($urandom % 32'h8018);
      2: a = 32'hFFFF_FFF0 + ($urandom % 16);
      3: a = (($urandom % 16) << 28) - ($urandom % 8);
      4: a = 32'hF000_0000 + ($urandom % 32'h0FFF_FFFF);
      default: a = $urandom;
    endcase
    return a;
  endfunction

  task automatic drive(bit rst, bit v, bit dma, bit [1:0] sz, bit [31:0] a, bit [31:0] mr,
                       bit frz, bit fl, bit clr);
    @(negedge clk);
    rst_l = !rst; valid_dc1 = v; dma_dc1 = dma; size_dc1 = sz; addr_dc1 = a;
    mrac = mr; freeze = frz; flush_dc2 = fl; fault_clr = clr;
    sb.push_back(ref_chk(rst, frz, fl, clr, v, dma, sz, a, mr));
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_dc2(ent_t m);
    bit acc, mis;
    if (!m.v) return '0;
    acc = m.code inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    mis = m.code inside {3'd5, 3'd6};
    return {1'b1, m.dccm, m.pic, m.ext, m.cache, m.side, acc, mis, m.code};
  endfunction

  function automatic logic [10:0] dut_dc2();
    return {valid_dc2, addr_in_dccm_dc2, addr_in_pic_dc2, addr_external_dc2, cacheable_dc2,
            sideeffects_dc2, access_fault_dc2, misaligned_fault_dc2, fault_code_dc2};
  endfunction

  // Monitor-side model state
  ent_t m2, m3, ent;
  bit mlock;
  bit [31:0] maddr;
  bit [2:0] mcode;
  logic [CNT_W-1:0] mcnt;

  task automatic model_reset();
    m2 = '{default: 0}; m3 = '{default: 0};
    mlock = 0; maddr = 0; mcode = 0; mcnt = '0;
  endtask

  task automatic monitor();
    bit hit;
    int it;
    it = 0;
    while (!(stim_done && sb.size() == 0) && it < 20000) begin
      it++;
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_underflow: got empty queue expected entry");
        continue;
      end
      ent = sb.pop_front();
      if (ent.rst) model_reset();
      else begin
        hit = m2.v && m2.code != 0 && !ent.frz && !ent.fl;
        if (hit && (!mlock || ent.clr)) begin
          mlock = 1; maddr = m2.addr; mcode = m2.code;
        end else if (ent.clr) mlock = 0;
        if (hit && mcnt != {CNT_W{1'b1}}) mcnt = mcnt + 1'b1;
        if (ent.fl) begin
          m2.v = 0; m3.v = 0;
        end else if (!ent.frz) begin
          m3 = m2; m2 = ent;
        end
      end
      chk("dc2", 64'(dut_dc2()), 64'(exp_dc2(m2)));
      chk("dc3", 64'({valid_dc3, sideeffects_dc3}), 64'({m3.v, m3.v && m3.side}));
      chk("fault", 64'({fault_lock, fault_code, fault_addr, fault_cnt}),
          64'({mlock, mcode, maddr, mcnt}));
    end
    if (!(stim_done && sb.size() == 0)) begin
      n_vec++; n_err++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic stimulus();
    // Basic classification and fault cases
    drive(0, 1, 0, 2, 32'hF004_0010, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 2, 32'hF005_0000, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 3, 32'h1FFF_FFFC, 32'h8, 0, 0, 0);
    drive(0, 1, 0, 1, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 2, 32'hF00C_0002, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'hF00C_0000, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 2, 32'hF004_FFFE, 32'h0, 0, 0, 0);
    drive(0, 1, 1, 2, 32'hF005_0000, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h2000_0001, 32'hFFFF_FFFF, 0, 0, 0);
    // Freeze three cycles with changing dc1, then flush while frozen
    drive(0, 1, 0, 2, 32'hF004_0020, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h3000_1000, 32'hC0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 2, 32'hF005_0000 + i, $urandom, 1, 0, 0);
    drive(0, 1, 0, 2, 32'hF004_0040, 32'h0, 1, 1, 0);
    drive(0, 1, 0, 2, 32'hF004_0044, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // Saturate the fault counter
    for (int i = 0; i < (1 << CNT_W) + 4; i++)
      drive(0, 1, 0, 2, 32'hF005_0000 + (i << 4), 32'h0, 0, 0, 0);
    // Clear coincident with a retiring fault, then clear alone
    drive(0, 1, 0, 2, 32'hF006_0040, 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    // Reset while frozen discards held contents
    drive(0, 1, 0, 2, 32'hF005_0010, 32'h0, 0, 0, 0);
    drive(0, 1, 0, 2, 32'hF004_0030, 32'h0, 1, 0, 0);
    drive(1, 1, 0, 2, 32'hF004_0030, 32'h0, 1, 0, 0);
    drive(0, 1, 0, 2, 32'hF004_0034, 32'h0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 2500; i++)
      drive(($urandom % 400) == 0, ($urandom % 5) != 0, ($urandom % 5) == 0,
            2'($urandom), pick_addr(), $urandom, ($urandom % 5) == 0,
            ($urandom % 10) == 0, ($urandom % 8) == 0);
    stim_done = 1;
  endtask

  initial begin
    rst_l = 0; freeze = 0; flush_dc2 = 0; valid_dc1 = 0; dma_dc1 = 0;
    size_dc1 = 0; addr_dc1 = 0; mrac = 0; fault_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dc2", 64'(dut_dc2()), 64'd0);
    chk("reset_dc3", 64'({valid_dc3, sideeffects_dc3}), 64'd0);
    chk("reset_fault", 64'({fault_lock, fault_code, fault_addr, fault_cnt}), 64'd0);
    rst_l = 1;
    @(posedge clk);
    fork
      stimulus();
      monitor();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
